lemon_seq: RTL and testbench

Multi-cycle sequencer for the LemonPC core. Owns the PC and a single shared memory port, and steps each instruction through fetch, execute, optional data access and commit. The combinational decode/ALU datapath sits beside it, fed by the latched instruction. Instruction fetch and load/store share the port by time-multiplexing: only one request is ever outstanding.

---
 rtl/lemon_seq.sv | 118 +++++++++++
 tb/tb_lemon_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lemon_seq.sv
// lemon_seq: multi-cycle fetch/execute/memory/commit sequencer owning the PC and one shared memory port.
// Define LEMON_SEQ_PERF_EN to expose the cycle and retire counters; otherwise they read as zero.
module lemon_seq #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic [63:0] pc_o,
  output logic [31:0] inst_o,
  input  logic        dp_mem_wen,
  input  logic        dp_mem_ren,
  input  logic [63:0] dp_mem_addr,
  input  logic [63:0] dp_mem_wdata,
  input  logic [7:0]  dp_mem_mask,
  input  logic [63:0] dp_next_pc,
  input  logic        dp_reg_wen,
  input  logic        dp_ebreak,
  output logic [63:0] load_data,
  output logic        reg_wen_o,
  output logic        pc_wen,
  output logic        halt,
  output logic        err,
  output logic [63:0] cycle_cnt,
  output logic [63:0] retire_cnt
);
  typedef enum logic [2:0] {FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, COMMIT, HALT, ERROR} state_t;
  localparam logic [9:0] LIMIT = 10'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d, load_q, load_d;
  logic [31:0] inst_q, inst_d;
  logic [9:0]  wait_q, wait_d;
  logic        waiting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0013;
      load_q  <= 64'h0;
      wait_q  <= 10'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      load_q  <= load_d;
      wait_q  <= wait_d;
    end
  end

  // LIMIT is the last wait cycle; a response in that cycle still wins over the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_REQ:  state_d = pc_q[1:0] != 2'b00 ? ERROR : mem_req_ready ? FETCH_WAIT : FETCH_REQ;
      FETCH_WAIT: state_d = mem_resp_valid ? EXEC : wait_q == LIMIT ? ERROR : FETCH_WAIT;
      EXEC:       state_d = dp_ebreak ? HALT : (dp_mem_wen || dp_mem_ren) ? MEM_REQ : COMMIT;
      MEM_REQ:    state_d = mem_req_ready ? MEM_WAIT : MEM_REQ;
      MEM_WAIT:   state_d = mem_resp_valid ? COMMIT : wait_q == LIMIT ? ERROR : MEM_WAIT;
      COMMIT:     state_d = FETCH_REQ;
      default:    state_d = state_q;
    endcase
  end

  always_comb begin
    waiting = state_q == FETCH_WAIT || state_q == MEM_WAIT;
    wait_d  = (waiting && !mem_resp_valid) ? wait_q + 10'd1 : 10'd0;
    pc_d    = state_q == COMMIT ? dp_next_pc : pc_q;
    inst_d  = (state_q == FETCH_WAIT && mem_resp_valid) ?
              (pc_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0]) : inst_q;
    load_d  = (state_q == MEM_WAIT && mem_resp_valid && !dp_mem_wen) ? mem_resp_data : load_q;
  end

  always_comb begin
    mem_req_valid = !rst && ((state_q == FETCH_REQ && pc_q[1:0] == 2'b00) || state_q == MEM_REQ);
    mem_req_addr  = state_q == MEM_REQ ? dp_mem_addr : {pc_q[63:3], 3'b000};
    mem_req_wen   = state_q == MEM_REQ && dp_mem_wen;
    mem_req_wdata = state_q == MEM_REQ ? dp_mem_wdata : 64'h0;
    mem_req_mask  = state_q == MEM_REQ ? dp_mem_mask : 8'h0f;
    pc_wen        = state_q == COMMIT;
    reg_wen_o     = state_q == COMMIT && dp_reg_wen;
    halt          = state_q == HALT;
    err           = state_q == ERROR;
    pc_o          = pc_q;
    inst_o        = inst_q;
    load_data     = load_q;
  end

`ifdef LEMON_SEQ_PERF_EN
  logic [63:0] cyc_q, cyc_d, ret_q, ret_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 64'h0;
      ret_q <= 64'h0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end
  always_comb begin
    cyc_d = (state_q == HALT || state_q == ERROR) ? cyc_q : cyc_q + 64'd1;
    ret_d = ret_q + {63'b0, state_q == COMMIT || (state_q == EXEC && dp_ebreak)};
  end
  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;
`else
  assign cycle_cnt  = 64'h0;
  assign retire_cnt = 64'h0;
`endif
endmodule

// File: tb/tb_lemon_seq.sv
// tb_lemon_seq: directed checks of the lemon_seq sequencer with the bench acting as memory and datapath.
module tb_lemon_seq;
  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam int TO = 1023;
`ifdef LEMON_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [7:0]  mem_req_mask, dp_mem_mask;
  logic [63:0] pc_o, dp_mem_addr, dp_mem_wdata, dp_next_pc, load_data, cycle_cnt, retire_cnt;
  logic [31:0] inst_o;
  logic        dp_mem_wen, dp_mem_ren, dp_reg_wen, dp_ebreak, reg_wen_o, pc_wen, halt, err;
  int n_checks = 0, n_fail = 0;

  lemon_seq #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .pc_o(pc_o), .inst_o(inst_o),
    .dp_mem_wen(dp_mem_wen), .dp_mem_ren(dp_mem_ren), .dp_mem_addr(dp_mem_addr),
    .dp_mem_wdata(dp_mem_wdata), .dp_mem_mask(dp_mem_mask), .dp_next_pc(dp_next_pc),
    .dp_reg_wen(dp_reg_wen), .dp_ebreak(dp_ebreak),
    .load_data(load_data), .reg_wen_o(reg_wen_o), .pc_wen(pc_wen), .halt(halt), .err(err),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clear_inputs;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    dp_mem_wen = 0; dp_mem_ren = 0; dp_mem_addr = 0; dp_mem_wdata = 0; dp_mem_mask = 0;
    dp_next_pc = 0; dp_reg_wen = 0; dp_ebreak = 0;
  endtask

  task do_reset;
    clear_inputs();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task release_rst;
    rst = 0;
    #1;
  endtask

  // Zero-wait fetch: starts in FETCH_REQ, returns in EXEC
  task fetch(input logic [63:0] word);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = word;
    tick();
    mem_resp_valid = 0; mem_resp_data = 0;
  endtask

  task test_reset;
    do_reset();
    n_checks++;
    if ({mem_req_valid, pc_wen, reg_wen_o, halt, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 00000", {mem_req_valid, pc_wen, reg_wen_o, halt, err});
    end
    n_checks++;
    if (pc_o !== RPC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_o, RPC); end
    n_checks++;
    if (inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h want 00000013", inst_o); end
    n_checks++;
    if ({load_data, cycle_cnt, retire_cnt} !== 192'h0) begin
      n_fail++; $display("FAIL reset_data_cnt: load %h cyc %h ret %h want 0", load_data, cycle_cnt, retire_cnt);
    end
    release_rst();
    n_checks++;
    if ({mem_req_valid, mem_req_wen, mem_req_mask} !== 10'b1_0_00001111) begin
      n_fail++; $display("FAIL first_fetch_ctl: got %b want 1000001111", {mem_req_valid, mem_req_wen, mem_req_mask});
    end
    n_checks++;
    if (mem_req_addr !== RPC) begin n_fail++; $display("FAIL first_fetch_addr: got %h want %h", mem_req_addr, RPC); end
  endtask

  task test_program;
    logic pend;
    do_reset();
    release_rst();
    pend = 0;
    for (int c = 1; c <= 15; c++) begin
      mem_req_ready = 1; mem_resp_valid = pend; mem_resp_data = 64'h0020_0113_0010_0093;
      dp_next_pc = pc_o + 64'd4; dp_ebreak = (pc_o == RPC + 64'd12); dp_reg_wen = 1;
      #1;
      n_checks++;
      if (pc_wen !== (c == 4 || c == 8 || c == 12)) begin
        n_fail++; $display("FAIL prog_pc_wen cycle %0d: got %b want %b", c, pc_wen, (c == 4 || c == 8 || c == 12));
      end
      if (c == 3) begin
        n_checks++;
        if (inst_o !== 32'h0010_0093) begin n_fail++; $display("FAIL prog_inst_lo: got %h want 00100093", inst_o); end
      end
      if (c == 7) begin
        n_checks++;
        if (inst_o !== 32'h0020_0113) begin n_fail++; $display("FAIL prog_inst_hi: got %h want 00200113", inst_o); end
      end
      pend = mem_req_valid && mem_req_ready;
      tick();
    end
    n_checks++;
    if ({halt, err, mem_req_valid} !== 3'b100) begin
      n_fail++; $display("FAIL prog_halt: halt/err/valid got %b want 100", {halt, err, mem_req_valid});
    end
    n_checks++;
    if (retire_cnt !== (PERF ? 64'd4 : 64'd0)) begin
      n_fail++; $display("FAIL prog_retire: got %0d want %0d", retire_cnt, PERF ? 4 : 0);
    end
    n_checks++;
    if (pc_o !== RPC + 64'd12) begin n_fail++; $display("FAIL prog_halt_pc: got %h want %h", pc_o, RPC + 64'd12); end
    mem_resp_valid = 0;
    repeat (3) tick();
    n_checks++;
    if ({halt, mem_req_valid} !== 2'b10) begin
      n_fail++; $display("FAIL halt_sticky: halt/valid got %b want 10", {halt, mem_req_valid});
    end
    n_checks++;
    if (cycle_cnt !== (PERF ? 64'd15 : 64'd0)) begin
      n_fail++; $display("FAIL prog_cycles: got %0d want %0d", cycle_cnt, PERF ? 15 : 0);
    end
    clear_inputs();
  endtask

  task test_store_stall;
    do_reset();
    release_rst();
    fetch(64'h0000_0013_00b5_3023);
    dp_mem_wen = 1; dp_mem_addr = 64'h8000_1000; dp_mem_wdata = 64'h1122_3344_5566_7788;
    dp_mem_mask = 8'hff; dp_next_pc = RPC + 64'd4;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      n_checks++;
      if ({mem_req_valid, mem_req_wen} !== 2'b11) begin
        n_fail++; $display("FAIL store_ctl cycle %0d: valid/wen got %b want 11", i, {mem_req_valid, mem_req_wen});
      end
      n_checks++;
      if ({mem_req_addr, mem_req_wdata, mem_req_mask} !== {64'h8000_1000, 64'h1122_3344_5566_7788, 8'hff}) begin
        n_fail++; $display("FAIL store_fields cycle %0d: addr %h wdata %h mask %h", i, mem_req_addr, mem_req_wdata, mem_req_mask);
      end
      tick();
    end
    mem_req_ready = 0;
    n_checks++;
    if ({pc_wen, mem_req_valid} !== 2'b00) begin
      n_fail++; $display("FAIL store_wait: pc_wen/valid got %b want 00", {pc_wen, mem_req_valid});
    end
    mem_resp_valid = 1; mem_resp_data = 64'hffff_ffff_ffff_ffff;
    tick();
    mem_resp_valid = 0; mem_resp_data = 0;
    n_checks++;
    if ({pc_wen, reg_wen_o} !== 2'b10) begin
      n_fail++; $display("FAIL store_commit cycle 9: pc_wen/reg_wen got %b want 10", {pc_wen, reg_wen_o});
    end
    tick();
    clear_inputs();
    n_checks++;
    if ({pc_o, load_data} !== {RPC + 64'd4, 64'h0}) begin
      n_fail++; $display("FAIL store_after: pc %h load %h want %h 0", pc_o, load_data, RPC + 64'd4);
    end
  endtask

  task test_load_delay;
    fetch(64'hcafe_0013_0000_0000);
    n_checks++;
    if (inst_o !== 32'hcafe_0013) begin n_fail++; $display("FAIL load_inst_hi: got %h want cafe0013", inst_o); end
    dp_mem_ren = 1; dp_mem_addr = 64'h8000_2000; dp_mem_mask = 8'hff; dp_reg_wen = 1; dp_next_pc = RPC + 64'd8;
    tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({pc_wen, reg_wen_o} !== 2'b00) begin
        n_fail++; $display("FAIL load_wait cycle %0d: pc_wen/reg_wen got %b want 00", i, {pc_wen, reg_wen_o});
      end
      tick();
    end
    mem_resp_valid = 1; mem_resp_data = 64'hdead_beef_0123_4567;
    tick();
    mem_resp_valid = 0; mem_resp_data = 0;
    n_checks++;
    if ({pc_wen, reg_wen_o} !== 2'b11) begin
      n_fail++; $display("FAIL load_commit: pc_wen/reg_wen got %b want 11", {pc_wen, reg_wen_o});
    end
    n_checks++;
    if (load_data !== 64'hdead_beef_0123_4567) begin
      n_fail++; $display("FAIL load_data: got %h want deadbeef01234567", load_data);
    end
    tick();
    n_checks++;
    if ({reg_wen_o, pc_o} !== {1'b0, RPC + 64'd8}) begin
      n_fail++; $display("FAIL load_after: reg_wen %b pc %h want 0 %h", reg_wen_o, pc_o, RPC + 64'd8);
    end
    clear_inputs();
  endtask

  task test_misaligned;
    fetch(64'h0);
    dp_next_pc = 64'h8000_0002;
    tick();
    tick();
    mem_req_ready = 1;
    n_checks++;
    if ({mem_req_valid, err, pc_o} !== {2'b00, 64'h8000_0002}) begin
      n_fail++; $display("FAIL misalign_req: valid %b err %b pc %h want 0 0 80000002", mem_req_valid, err, pc_o);
    end
    tick();
    n_checks++;
    if ({err, mem_req_valid} !== 2'b10) begin
      n_fail++; $display("FAIL misalign_err: err/valid got %b want 10", {err, mem_req_valid});
    end
    repeat (2) tick();
    n_checks++;
    if ({err, mem_req_valid, halt} !== 3'b100) begin
      n_fail++; $display("FAIL err_sticky: err/valid/halt got %b want 100", {err, mem_req_valid, halt});
    end
    clear_inputs();
  endtask

  task test_timeout;
    do_reset();
    release_rst();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    repeat (TO - 1) tick();
    n_checks++;
    if ({err, mem_req_valid} !== 2'b00) begin
      n_fail++; $display("FAIL timeout_early: err/valid got %b want 00", {err, mem_req_valid});
    end
    tick();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
    do_reset();
    release_rst();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    repeat (TO - 1) tick();
    mem_resp_valid = 1; mem_resp_data = 64'h13;
    tick();
    mem_resp_valid = 0;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_limit_resp: err got %b want 0", err); end
    dp_next_pc = RPC + 64'd4;
    tick();
    n_checks++;
    if (pc_wen !== 1'b1) begin n_fail++; $display("FAIL timeout_limit_commit: pc_wen got %b want 1", pc_wen); end
    clear_inputs();
  endtask

  task test_reset_midflight;
    do_reset();
    release_rst();
    fetch(64'h0);
    dp_next_pc = RPC + 64'd4; dp_reg_wen = 1;
    tick();
    tick();
    fetch(64'h0);
    dp_mem_ren = 1; dp_mem_addr = 64'h8000_3000; dp_mem_mask = 8'hff; dp_next_pc = RPC + 64'd8;
    tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    tick();
    rst = 1;
    #1;
    n_checks++;
    if ({mem_req_valid, pc_wen, reg_wen_o, halt, err} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_strobes: got %b want 00000", {mem_req_valid, pc_wen, reg_wen_o, halt, err});
    end
    n_checks++;
    if ({pc_o, inst_o, cycle_cnt, retire_cnt} !== {RPC, 32'h13, 128'h0}) begin
      n_fail++; $display("FAIL midrst_state: pc %h inst %h cyc %h ret %h", pc_o, inst_o, cycle_cnt, retire_cnt);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 0;
    mem_resp_valid = 1; mem_resp_data = 64'h5555_aaaa_5555_aaaa;
    #1;
    n_checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, RPC}) begin
      n_fail++; $display("FAIL midrst_refetch: valid %b addr %h want 1 %h", mem_req_valid, mem_req_addr, RPC);
    end
    tick();
    mem_resp_valid = 0; mem_resp_data = 0;
    n_checks++;
    if ({mem_req_valid, inst_o, load_data} !== {1'b1, 32'h13, 64'h0}) begin
      n_fail++; $display("FAIL midrst_late_resp: valid %b inst %h load %h want 1 00000013 0", mem_req_valid, inst_o, load_data);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_program();
    test_store_stall();
    test_load_delay();
    test_misaligned();
    test_timeout();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
